// File: rtl/weight_fetch_scheduler.sv
// Weight fetch scheduler: walks every (filter, channel) tuple, requests each
// kernel from the weight ROM, and streams the kernels through a 2-entry
// skid buffer to the downstream consumer with filter/channel/last tags.
module weight_fetch_scheduler #(
   parameter int NUM_FILTERS    = 64,
   parameter int INPUT_CHANNELS = 3,
   parameter int KERNEL_SIZE    = 3,
   parameter int WEIGHT_WIDTH   = 8,
   parameter int TIMEOUT        = 31,
   localparam int KW = KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH,
   localparam int FW = $clog2(NUM_FILTERS),
   localparam int CW = $clog2(INPUT_CHANNELS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          err_timeout,
   input  logic          rom_ready,
   output logic          rom_read_enable,
   output logic [FW-1:0] rom_filter_idx,
   output logic [CW-1:0] rom_channel_idx,
   input  logic [KW-1:0] rom_weight_in,
   input  logic          rom_weight_valid,
   output logic          w_valid,
   input  logic          w_ready,
   output logic [KW-1:0] w_data,
   output logic [FW-1:0] w_filter_idx,
   output logic [CW-1:0] w_channel_idx,
   output logic          w_last_channel,
   output logic          w_last
);

   localparam int TW = $clog2(TIMEOUT+1);

   typedef enum logic [2:0] {IDLE, WAIT_ROM, ISSUE, WAIT_DATA, HOLD, DRAIN} state_t;

   typedef struct packed {
      logic [KW-1:0] data;
      logic [FW-1:0] filt;
      logic [CW-1:0] chan;
      logic          last_ch;
      logic          last;
   } ent_t;

   state_t        state, nxt;
   logic [FW-1:0] filt_cnt;
   logic [CW-1:0] chan_cnt;
   logic [TW-1:0] tcnt;
   logic          err_q;
   ent_t          ent0, ent1, new_ent;
   logic [1:0]    cnt, occ_next;
   logic          last_ch_cur, last_cur, pop, capture, tmo_hit, tmo_set, flush;

   assign last_ch_cur = (chan_cnt == CW'(INPUT_CHANNELS-1));
   assign last_cur    = last_ch_cur && (filt_cnt == FW'(NUM_FILTERS-1));
   assign pop         = (cnt != 2'd0) && w_ready;
   // Once the counter has hit TIMEOUT the pass is dead; a late pulse is dropped.
   assign tmo_hit     = (state == WAIT_DATA) && (tcnt == TW'(TIMEOUT));
   assign capture     = (state == WAIT_DATA) && rom_weight_valid && !tmo_hit && !abort;
   assign tmo_set     = (state == WAIT_DATA) && !rom_weight_valid && !abort &&
                        (tcnt == TW'(TIMEOUT-1));
   assign flush       = (abort && (state != IDLE)) || (tmo_hit && !abort);
   assign occ_next    = cnt + {1'b0, capture} - {1'b0, pop};
   assign new_ent     = '{data: rom_weight_in, filt: filt_cnt, chan: chan_cnt,
                          last_ch: last_ch_cur, last: last_cur};

   assign busy            = (state != IDLE);
   assign rom_read_enable = (state == ISSUE);
   assign rom_filter_idx  = filt_cnt;
   assign rom_channel_idx = chan_cnt;
   assign err_timeout     = err_q;
   assign w_valid         = (cnt != 2'd0);
   assign w_data          = ent0.data;
   assign w_filter_idx    = ent0.filt;
   assign w_channel_idx   = ent0.chan;
   assign w_last_channel  = ent0.last_ch;
   assign w_last          = ent0.last;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next-state decode and the completion pulse; abort overrides everything.
   always_comb begin
      nxt  = state;
      done = 1'b0;
      case (state)
         IDLE:      if (start) nxt = WAIT_ROM;
         WAIT_ROM:  if (rom_ready) nxt = ISSUE;
         ISSUE:     nxt = WAIT_DATA;
         WAIT_DATA: begin
            if (capture) begin
               if (last_cur)              nxt = DRAIN;
               else if (occ_next < 2'd2)  nxt = WAIT_ROM;
               else                       nxt = HOLD;
            end else if (tmo_hit) begin
               nxt = IDLE;
            end
         end
         HOLD:      if (occ_next < 2'd2) nxt = WAIT_ROM;
         DRAIN: begin
            if (pop && ent0.last) begin
               done = 1'b1;
               nxt  = IDLE;
            end
         end
         default:   nxt = IDLE;
      endcase
      if (abort && (state != IDLE)) begin
         nxt  = IDLE;
         done = 1'b0;
      end
   end

   // Tuple counters, WAIT_DATA cycle counter and the sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_cnt <= '0;
         chan_cnt <= '0;
         tcnt     <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            filt_cnt <= '0;
            chan_cnt <= '0;
            err_q    <= 1'b0;
         end else if (capture && !last_cur) begin
            if (last_ch_cur) begin
               chan_cnt <= '0;
               filt_cnt <= filt_cnt + 1'b1;
            end else begin
               chan_cnt <= chan_cnt + 1'b1;
            end
         end
         if (tmo_set) err_q <= 1'b1;
         if (state == ISSUE)                  tcnt <= '0;
         else if (state == WAIT_DATA && !tmo_hit) tcnt <= tcnt + 1'b1;
      end
   end

   // 2-entry FIFO; ent0 is the head that drives the downstream outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0 <= '0;
         ent1 <= '0;
         cnt  <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else begin
         if (capture && pop) begin
            if (cnt == 2'd1) ent0 <= new_ent;
            else begin
               ent0 <= ent1;
               ent1 <= new_ent;
            end
         end else if (capture) begin
            if (cnt == 2'd0) ent0 <= new_ent;
            else             ent1 <= new_ent;
         end else if (pop) begin
            ent0 <= ent1;
         end
         cnt <= occ_next;
      end
   end

endmodule
